// File: rtl/priority_grant_arbiter.sv
// rtl/priority_grant_arbiter.sv - registered N-way arbiter, fixed or round-robin priority
// Grants one requester at a time with ack release, a hold-time limit and a rotating pointer.
module priority_grant_arbiter #(
    parameter int  N        = 8,
    parameter int  MAX_HOLD = 16,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic         timeout
);

    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [N-1:0]    gnt_onehot_q, gnt_onehot_d;
    logic            timeout_q, timeout_d;
    logic [W-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            rr_q, rr_d;

    logic [W-1:0]    win_fixed;
    logic [W-1:0]    win_rr;
    logic [W-1:0]    win_sel;
    logic            rr_found;
    int              rr_j;
    logic            owner_req;
    logic            at_limit;

    // Fixed: last set bit seen wins (highest index). Round-robin: first set bit from ptr upward.
    always_comb begin
        win_fixed = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) win_fixed = W'(i);
        end
        win_rr   = '0;
        rr_found = 1'b0;
        rr_j     = 0;
        for (int k = 0; k < N; k++) begin
            rr_j = int'(ptr_q) + k;
            if (rr_j >= N) rr_j = rr_j - N;
            if (!rr_found && req[W'(rr_j)]) begin
                win_rr   = W'(rr_j);
                rr_found = 1'b1;
            end
        end
        win_sel = mode ? win_rr : win_fixed;
    end

    assign owner_req = |(req & gnt_onehot_q);
    assign at_limit  = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD));

    always_comb begin
        state_d      = state_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        timeout_d    = 1'b0;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        rr_d         = rr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d      = GRANT;
                    gnt_valid_d  = 1'b1;
                    gnt_idx_d    = win_sel;
                    gnt_onehot_d = N'(1) << win_sel;
                    hold_cnt_d   = HW'(1);
                    rr_d         = mode;
                end
            end
            GRANT: begin
                if (ack || !owner_req || at_limit) begin
                    state_d      = IDLE;
                    gnt_valid_d  = 1'b0;
                    gnt_idx_d    = '0;
                    gnt_onehot_d = '0;
                    hold_cnt_d   = '0;
                    // Only a pure hold-limit release counts as a timeout.
                    timeout_d    = at_limit && !ack && owner_req;
                    if (rr_q) begin
                        ptr_d = (gnt_idx_q == W'(N - 1)) ? '0 : gnt_idx_q + W'(1);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            timeout_q    <= 1'b0;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            rr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            timeout_q    <= timeout_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            rr_q         <= rr_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign timeout    = timeout_q;

endmodule
